// File: rtl/ped_pkg.sv
// Shared types and helpers for the pedestrian-crossing controller (ped_signal).
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        WALK  = 2'b10,
        CLEAR = 2'b11
    } ped_state_t;

    localparam int SYNC_STAGES = 2;

    // Vehicle lamps are healthy only when exactly one is lit; maintenance masks the check.
    function automatic logic lamp_fault(input logic maint, input logic r,
                                        input logic y, input logic g);
        logic [1:0] lit;
        lit = {1'b0, r} + {1'b0, y} + {1'b0, g};
        return ~maint & (lit != 2'd1);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button synchronizer: SYNC_STAGES flops into the clock domain, then a
// rising-edge pulse taken against one more flop so a held button yields one pulse.
module btn_sync_edge
    import ped_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // Synchronizer chain and edge-reference flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/ped_signal.sv
// Pedestrian-crossing controller: grants WALK inside a vehicle red interval, then a
// flashing clearance with countdown. Optional build macro PED_AUTO_WALK_EN grants on every red rise.
module ped_signal
    import ped_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FLASH_HALF = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             maintenance,
    input  logic             ped_button,
    input  logic [WIDTH-1:0] walk_duration,
    input  logic [WIDTH-1:0] clear_duration,
    output logic             walk,
    output logic             dont_walk,
    output logic             request_pending,
    output logic [WIDTH-1:0] countdown,
    output logic             abort
);

    localparam int             FW         = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0]  FLASH_LAST = FW'(FLASH_HALF - 1);

    ped_state_t       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             flash_q, flash_d;
    logic             req_q, req_d;
    logic             abort_q, abort_d;
    logic             red_q;

    logic             press_s;
    logic             red_rise_s;
    logic             fault_s;
    logic             grant_s;
    logic             cut_short_s;
    logic [WIDTH-1:0] walk_load_s;
    logic [WIDTH-1:0] clear_load_s;
    logic             walk_s;
    logic             dont_walk_s;
    logic [WIDTH-1:0] countdown_s;

    btn_sync_edge u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (ped_button),
        .rise_o (press_s)
    );

    assign red_rise_s   = red & ~red_q;
    assign fault_s      = lamp_fault(maintenance, red, yellow, green);
    assign grant_s      = red_rise_s & ~fault_s;
    assign cut_short_s  = ~maintenance & ((state_q == WALK) | (state_q == CLEAR)) & (~red | fault_s);
    // Counters hold "cycles remaining minus one", so a zero duration still gives one cycle.
    assign walk_load_s  = (walk_duration  == '0) ? '0 : walk_duration  - WIDTH'(1);
    assign clear_load_s = (clear_duration == '0) ? '0 : clear_duration - WIDTH'(1);

    // State, phase counters, request latch and abort pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            flash_q <= 1'b1;
            req_q   <= 1'b0;
            abort_q <= 1'b0;
            red_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            flash_q <= flash_d;
            req_q   <= req_d;
            abort_q <= abort_d;
            red_q   <= red;
        end
    end

    // Next-state: maintenance overrides everything, then abort, then normal sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        flash_d = flash_q;
        req_d   = req_q;
        abort_d = 1'b0;
        if (maintenance) begin
            state_d = IDLE;
            req_d   = req_q | press_s;
        end else if (cut_short_s) begin
            state_d = IDLE;
            abort_d = 1'b1;
            // Only a request made during clearance survives an abort.
            req_d   = (state_q == CLEAR) ? (req_q | press_s) : 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef PED_AUTO_WALK_EN
                    if (grant_s) begin
                        state_d = WALK;
                        cnt_d   = walk_load_s;
                        req_d   = 1'b0;
                    end else if (press_s | req_q) begin
                        state_d = WAIT;
                        req_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    if (press_s | req_q) begin
                        state_d = WAIT;
                        req_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
                WAIT: begin
                    if (grant_s) begin
                        state_d = WALK;
                        cnt_d   = walk_load_s;
                        req_d   = 1'b0;
                    end else begin
                        req_d   = 1'b1;
                    end
                end
                WALK: begin
                    if (cnt_q == '0) begin
                        state_d = CLEAR;
                        cnt_d   = clear_load_s;
                        flash_d = 1'b1;
                        fcnt_d  = '0;
                    end else begin
                        cnt_d   = cnt_q - WIDTH'(1);
                    end
                end
                CLEAR: begin
                    req_d = req_q | press_s;
                    if (fcnt_q == FLASH_LAST) begin
                        fcnt_d  = '0;
                        flash_d = ~flash_q;
                    end else begin
                        fcnt_d  = fcnt_q + FW'(1);
                    end
                    if (cnt_q == '0) begin
                        state_d = (req_q | press_s) ? WAIT : IDLE;
                    end else begin
                        cnt_d   = cnt_q - WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Moore lamp and display decode of the registered state
    always_comb begin
        walk_s      = 1'b0;
        dont_walk_s = 1'b1;
        countdown_s = '0;
        case (state_q)
            IDLE, WAIT: begin
                walk_s      = 1'b0;
                dont_walk_s = 1'b1;
            end
            WALK: begin
                walk_s      = 1'b1;
                dont_walk_s = 1'b0;
            end
            CLEAR: begin
                walk_s      = 1'b0;
                dont_walk_s = flash_q;
                countdown_s = cnt_q + WIDTH'(1);
            end
            default: begin
                walk_s      = 1'b0;
                dont_walk_s = 1'b1;
            end
        endcase
    end

    assign walk            = walk_s;
    assign dont_walk       = dont_walk_s;
    assign countdown       = countdown_s;
    assign request_pending = req_q;
    assign abort           = abort_q;

endmodule
